// File: rtl/neuron_mac_seq_if.sv
// neuron_mac_seq_if
//   Groups the stream and result handshakes for one neuron evaluation.
//   master: the producer of control, (x, w) pairs, and the consumer of results.
//   slave : the neuron sequencer itself.
//   Signals:
//     start, bias[7:0], relu_en       evaluation control (sampled on accepted start)
//     in_valid, in_ready, x_in, w_in  (activation, weight) pair stream
//     out_valid, out_ready, out_data  result handshake
//     busy                            high whenever the sequencer is not idle
interface neuron_mac_seq_if;
  logic       start;
  logic [7:0] bias;
  logic       relu_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in;
  logic [7:0] w_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  modport master (
    output start, bias, relu_en, in_valid, x_in, w_in, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, bias, relu_en, in_valid, x_in, w_in, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq
//   Computes one neuron's dot product on a single shared multiply-accumulate
//   datapath: acc = bias + sum(x*w) over N_INPUTS pairs, then an arithmetic
//   right shift by SHIFT, signed 8-bit saturation and optional ReLU.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     s_if   neuron_mac_seq_if.slave (start/bias/relu_en, pair stream,
//            result handshake, busy)
module neuron_mac_seq #(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 20,
  parameter int SHIFT    = 4
) (
  input logic             clk,
  input logic             rst_n,
  neuron_mac_seq_if.slave s_if
);

  // Count must reach N_INPUTS after the final accept, hence the +1.
  localparam int              CNT_W    = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FINISH,
    S_OUTPUT
  } state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_count;
  logic                    r_relu;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [7:0]              r_out_data;
  logic                    r_busy;

  logic                    w_accept;
  logic signed [15:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_shifted;
  logic                    w_fits;
  logic [7:0]              w_sat;
  logic [7:0]              w_result;

  // r_in_ready is only ever high in ACCUM, so it alone qualifies an accept.
  assign w_accept   = r_in_ready & s_if.in_valid;
  assign w_prod     = $signed(s_if.x_in) * $signed(s_if.w_in);
  assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-8){s_if.bias[7]}}, s_if.bias};

  // Arithmetic shift gives floor rounding for negative accumulators.
  assign w_shifted  = r_acc >>> SHIFT;
  // The value fits in signed 8 bits when every bit above bit 7 equals bit 7.
  assign w_fits     = (&w_shifted[ACC_W-1:7]) | ~(|w_shifted[ACC_W-1:7]);
  assign w_sat      = w_fits ? w_shifted[7:0]
                             : (w_shifted[ACC_W-1] ? 8'h80 : 8'h7F);
  assign w_result   = (r_relu && w_sat[7]) ? 8'h00 : w_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_relu      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_if.start) begin
            r_acc      <= w_bias_ext;
            r_count    <= '0;
            r_relu     <= s_if.relu_en;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc   <= r_acc + w_prod_ext;
            r_count <= r_count + CNT_W'(1);
            if (r_count == LAST_IDX) begin
              r_in_ready <= 1'b0;
              r_state    <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          r_out_data  <= w_result;
          r_out_valid <= 1'b1;
          r_state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (s_if.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_if.in_ready  = r_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_data  = r_out_data;
  assign s_if.busy      = r_busy;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq
//   Directed bench for neuron_mac_seq. A transaction-level model follows the
//   evaluation (collect pairs, resolve, present result) and a single negedge
//   process compares every DUT output against it each cycle. Hand-computed
//   literals pin both the model's arithmetic and the DUT's results.
module tb_neuron_mac_seq;
  localparam int N     = 4;
  localparam int ACC_W = 20;
  localparam int SHIFT = 4;

  logic clk;
  logic rst_n;

  neuron_mac_seq_if bus ();

  neuron_mac_seq #(.N_INPUTS(N), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Result rule: floor shift, clamp to signed 8 bits, optional ReLU.
  function automatic int ref_out(input int sum, input bit relu);
    int s;
    s = sum >>> SHIFT;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  // ---------------- transaction model ----------------
  typedef enum int {P_IDLE, P_COLLECT, P_RESOLVE, P_PRESENT} phase_t;
  phase_t m_phase = P_IDLE;
  int     m_sum   = 0;
  bit     m_relu  = 1'b0;
  int     m_prods[$];
  int     m_result = 0;
  int     m_out    = 0;
  int     dut_last = 0;
  int     g_accepts = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_out   = 0;
      m_sum   = 0;
      m_prods.delete();
    end
    chk("busy",      int'(bus.busy),      int'(m_phase != P_IDLE));
    chk("in_ready",  int'(bus.in_ready),  int'(m_phase == P_COLLECT));
    chk("out_valid", int'(bus.out_valid), int'(m_phase == P_PRESENT));
    chk("out_data",  int'($signed(bus.out_data)), m_out);
    if (bus.out_valid) dut_last = int'($signed(bus.out_data));
    if (bus.in_valid && bus.in_ready) g_accepts++;
    if (rst_n) begin
      case (m_phase)
        P_IDLE: if (bus.start) begin
          m_sum   = int'($signed(bus.bias));
          m_relu  = bus.relu_en;
          m_prods.delete();
          m_phase = P_COLLECT;
        end
        P_COLLECT: if (bus.in_valid) begin
          m_prods.push_back(int'($signed(bus.x_in)) * int'($signed(bus.w_in)));
          if (m_prods.size() == N) begin
            foreach (m_prods[i]) m_sum += m_prods[i];
            m_result = ref_out(m_sum, m_relu);
            m_phase  = P_RESOLVE;
          end
        end
        P_RESOLVE: begin
          m_out   = m_result;
          m_phase = P_PRESENT;
        end
        P_PRESENT: if (bus.out_ready) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic do_start(input logic [7:0] b, input logic r);
    bus.start = 1'b1; bus.bias = b; bus.relu_en = r;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.relu_en = ~r;      // later changes must not matter
    bus.bias = 8'h5A;
  endtask

  // Feeds npairs pairs; vpat gives in_valid for the first plen cycles.
  task automatic feed(input logic [31:0] xs, input logic [31:0] ws, input int npairs,
                      input logic [15:0] vpat, input int plen, input bit poke);
    int k = 0;
    int cyc = 0;
    while (k < npairs && cyc < 64) begin
      bus.in_valid = (cyc < plen) ? vpat[cyc] : 1'b1;
      bus.x_in = bus.in_valid ? xs[8*k +: 8] : 8'h55;
      bus.w_in = bus.in_valid ? ws[8*k +: 8] : 8'h33;
      bus.start = poke;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = poke;   // extra valid after the last pair must be ignored
    chk("feed_pairs", k, npairs);
  endtask

  task automatic finish_eval(input int hold, input bit poke, input int req, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 20);
    chk({nm, "_latency"}, n, 2);
    repeat (hold) begin
      @(posedge clk); #1;
      bus.start = poke;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.start = poke;      // start in the handshake cycle is ignored
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    chk(nm, dut_last, req);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int acc0;
  initial begin
    rst_n = 1'b1;
    bus.start = 0; bus.bias = 0; bus.relu_en = 0; bus.in_valid = 0;
    bus.x_in = 0; bus.w_in = 0; bus.out_ready = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data),  0);
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_in_ready",  int'(bus.in_ready),  0);

    // Pin the model arithmetic to hand-computed values.
    chk("ref_basic",    ref_out(160, 1'b0),    10);
    chk("ref_sat_pos",  ref_out(64516, 1'b0),  127);
    chk("ref_sat_neg",  ref_out(-65024, 1'b0), -128);
    chk("ref_neg",      ref_out(-1024, 1'b0),  -64);
    chk("ref_relu",     ref_out(-1024, 1'b1),  0);
    chk("ref_floor",    ref_out(-1, 1'b0),     -1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: 16*(1+2+3+4)=160 -> 10
    do_start(8'd0, 1'b0);
    feed(32'h10101010, {8'd4, 8'd3, 8'd2, 8'd1}, N, 16'hFFFF, 16, 1'b0);
    finish_eval(0, 1'b0, 10, "basic");

    // Positive saturation
    do_start(8'd0, 1'b0);
    feed(32'h7F7F7F7F, 32'h7F7F7F7F, N, 16'hFFFF, 16, 1'b0);
    finish_eval(1, 1'b0, 127, "sat_pos");

    // Negative saturation
    do_start(8'd0, 1'b0);
    feed(32'h80808080, 32'h7F7F7F7F, N, 16'hFFFF, 16, 1'b0);
    finish_eval(0, 1'b0, -128, "sat_neg");

    // Negative without / with ReLU (relu_en flips after start inside do_start)
    do_start(8'd0, 1'b0);
    feed(32'hF0F0F0F0, 32'h10101010, N, 16'hFFFF, 16, 1'b0);
    finish_eval(0, 1'b0, -64, "neg_norelu");
    do_start(8'd0, 1'b1);
    feed(32'hF0F0F0F0, 32'h10101010, N, 16'hFFFF, 16, 1'b0);
    finish_eval(0, 1'b0, 0, "neg_relu");

    // Gapped valid, bias -5, stalled output with start pokes
    acc0 = g_accepts;
    do_start(8'hFB, 1'b0);
    feed(32'h01010101, 32'h01010101, N, 16'h00B2, 8, 1'b0);
    bus.in_valid = 1'b1;
    finish_eval(5, 1'b1, -1, "bias_gap");
    chk("bias_gap_accepts", g_accepts - acc0, 4);

    // Reset abort after two accepts
    do_start(8'd0, 1'b0);
    feed(32'h10101010, {8'd4, 8'd3, 8'd2, 8'd1}, 2, 16'hFFFF, 16, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_data", int'(bus.out_data), 0);
    chk("abort_busy",     int'(bus.busy),     0);
    chk("abort_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh evaluation with start held high through ACCUM/FINISH/OUTPUT
    do_start(8'd0, 1'b0);
    feed(32'h10101010, {8'd4, 8'd3, 8'd2, 8'd1}, N, 16'hFFFF, 16, 1'b1);
    finish_eval(2, 1'b1, 10, "after_abort");

    // Start in the very first IDLE cycle is accepted
    do_start(8'd0, 1'b0);
    chk("first_idle_busy", int'(bus.busy), 1);
    feed(32'h10101010, {8'd4, 8'd3, 8'd2, 8'd1}, N, 16'hFFFF, 16, 1'b0);
    finish_eval(0, 1'b0, 10, "first_idle");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
